// File: rtl/unpack.sv
// rtl/unpack.sv - sync-word search, lock tracking and byte reassembly for the serial packet stream
//
// Purpose:
//   Finds packet boundaries in a serial bit stream by searching for a 32-bit
//   sync word. Once a sync word is found, the block checks that every
//   following packet starts with a sync word exactly one packet length later.
//   Idle packets are discarded. The payload of each data packet is rebuilt
//   into bytes, MSB first, and the bytes leave through a small ready/valid FIFO.
//
// Ports:
//   i_clk       clock
//   i_reset     synchronous, active-high reset
//   i_data      serial bit, qualified by i_valid
//   i_valid     bit strobe; the stream cannot be stalled
//   o_data      payload byte at the FIFO head (first received bit in bit 7)
//   o_last      the head byte is the last byte of its packet
//   o_valid     FIFO not empty
//   i_ready     consumer takes the head byte when o_valid && i_ready
//   o_locked    sync tracking established
//   o_lock_err  one-cycle pulse when sync is lost
//   o_overflow  sticky: a byte was dropped because the FIFO was full

module unpack #(
   parameter int          SIZE_BIT_PACK   = 1976,
   parameter int          SIZE_PREAMBLE   = 32,
   parameter int          SIZE_OUTPUT_BIT = 8,
   parameter logic [31:0] PREAMBLE_DATA   = 32'h1ACFFC1D,
   parameter logic [31:0] PREAMBLE_IDLE   = 32'hE53003E2,
   parameter int          FIFO_DEPTH      = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_data,
   input  logic                       i_valid,
   output logic [SIZE_OUTPUT_BIT-1:0] o_data,
   output logic                       o_last,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic                       o_locked,
   output logic                       o_lock_err,
   output logic                       o_overflow
);

   localparam int CNT_W    = $clog2(SIZE_BIT_PACK);
   localparam int BCNT_W   = $clog2(SIZE_OUTPUT_BIT);
   localparam int ADDR_W   = $clog2(FIFO_DEPTH);
   localparam int PAY_BITS = SIZE_BIT_PACK - SIZE_PREAMBLE;

   localparam logic [CNT_W-1:0]  PAY_LAST  = CNT_W'(PAY_BITS - 1);
   localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(SIZE_PREAMBLE - 1);
   localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(SIZE_OUTPUT_BIT - 1);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_IDLE   = 2'd2;
   localparam logic [1:0] ST_HDR    = 2'd3;

   logic [1:0]                 r_state;
   logic [SIZE_PREAMBLE-1:0]   r_sr;
   logic [CNT_W-1:0]           r_cnt;
   logic [BCNT_W-1:0]          r_bcnt;
   logic [SIZE_OUTPUT_BIT-1:0] r_byte;
   logic                       r_locked;
   logic                       r_lock_err;
   logic                       r_overflow;

   // FIFO entries hold {last, byte}
   logic [SIZE_OUTPUT_BIT:0]   r_mem [FIFO_DEPTH];
   logic [ADDR_W:0]            r_wptr;
   logic [ADDR_W:0]            r_rptr;

   logic [SIZE_PREAMBLE-1:0]   w_cand;
   logic                       w_is_data;
   logic                       w_is_idle;
   logic                       w_empty;
   logic                       w_full;
   logic                       w_pop;
   logic                       w_push_req;
   logic                       w_push_ok;
   logic [SIZE_OUTPUT_BIT-1:0] w_push_byte;
   logic                       w_push_last;

   // The sync compare sees the bit being sampled this edge, so a decision
   // is made on the same edge that samples the 32nd sync bit.
   assign w_cand    = {r_sr[SIZE_PREAMBLE-2:0], i_data};
   assign w_is_data = (w_cand == PREAMBLE_DATA[SIZE_PREAMBLE-1:0]);
   assign w_is_idle = (w_cand == PREAMBLE_IDLE[SIZE_PREAMBLE-1:0]);

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
   assign w_pop   = !w_empty && i_ready;

   assign w_push_req  = i_valid && (r_state == ST_DATA) && (r_bcnt == BYTE_LAST);
   assign w_push_byte = {r_byte[SIZE_OUTPUT_BIT-2:0], i_data};
   assign w_push_last = (r_cnt == PAY_LAST);
   // A pop frees the slot this push needs, so push at full succeeds then
   assign w_push_ok   = !w_full || w_pop;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_SEARCH;
         r_sr       <= '0;
         r_cnt      <= '0;
         r_bcnt     <= '0;
         r_byte     <= '0;
         r_locked   <= 1'b0;
         r_lock_err <= 1'b0;
         r_overflow <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            r_mem[k] <= '0;
         end
      end else begin
         r_lock_err <= 1'b0;

         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end

         if (w_push_req) begin
            if (w_push_ok) begin
               r_mem[r_wptr[ADDR_W-1:0]] <= {w_push_last, w_push_byte};
               r_wptr <= r_wptr + 1'b1;
            end else begin
               r_overflow <= 1'b1;
            end
         end

         if (i_valid) begin
            r_sr <= w_cand;
            case (r_state)
               ST_SEARCH: begin
                  if (w_is_data) begin
                     r_state  <= ST_DATA;
                     r_cnt    <= '0;
                     r_bcnt   <= '0;
                     r_locked <= 1'b1;
                  end else if (w_is_idle) begin
                     r_state  <= ST_IDLE;
                     r_cnt    <= '0;
                     r_locked <= 1'b1;
                  end
               end

               ST_DATA: begin
                  r_byte <= w_push_byte;
                  if (r_bcnt == BYTE_LAST) begin
                     r_bcnt <= '0;
                  end else begin
                     r_bcnt <= r_bcnt + 1'b1;
                  end
                  if (r_cnt == PAY_LAST) begin
                     r_state <= ST_HDR;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               ST_IDLE: begin
                  if (r_cnt == PAY_LAST) begin
                     r_state <= ST_HDR;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               default: begin
                  // HDR: the next sync word must land exactly here
                  if (r_cnt == HDR_LAST) begin
                     r_cnt <= '0;
                     if (w_is_data) begin
                        r_state <= ST_DATA;
                        r_bcnt  <= '0;
                     end else if (w_is_idle) begin
                        r_state <= ST_IDLE;
                     end else begin
                        // sr keeps this word so search restarts in-stream
                        r_state    <= ST_SEARCH;
                        r_locked   <= 1'b0;
                        r_lock_err <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign o_data     = r_mem[r_rptr[ADDR_W-1:0]][SIZE_OUTPUT_BIT-1:0];
   assign o_last     = r_mem[r_rptr[ADDR_W-1:0]][SIZE_OUTPUT_BIT];
   assign o_valid    = !w_empty;
   assign o_locked   = r_locked;
   assign o_lock_err = r_lock_err;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_unpack.sv
// tb/tb_unpack.sv - directed scoreboard bench for unpack

module tb_unpack;

   localparam logic [31:0] P_DATA    = 32'h1ACFFC1D;
   localparam logic [31:0] P_IDLE    = 32'hE53003E2;
   localparam int          PAY_BYTES = 243;

   logic       i_clk;
   logic       i_reset;
   logic       i_data;
   logic       i_valid;
   logic [7:0] o_data;
   logic       o_last;
   logic       o_valid;
   logic       i_ready;
   logic       o_locked;
   logic       o_lock_err;
   logic       o_overflow;

   logic [8:0] exp_q [$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_lock_err = 0;

   unpack dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .o_data     (o_data),
      .o_last     (o_last),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_locked   (o_locked),
      .o_lock_err (o_lock_err),
      .o_overflow (o_overflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
      end
   endtask

   // Consumer side: a handshake seen at the falling edge completes on the next rising edge
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (o_lock_err) n_lock_err++;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", {23'd0, o_last, o_data}, 32'h1ff);
            end else begin
               check("byte", {23'd0, o_last, o_data}, {23'd0, exp_q[0]});
               void'(exp_q.pop_front());
            end
         end
      end
   end

   function automatic logic [7:0] pay(input int mode, input int j);
      case (mode)
         0:       pay = 8'(j);
         1:       pay = 8'(j) ^ 8'hA5;
         default: pay = 8'h00;
      endcase
   endfunction

   task automatic send_bit(input logic b, input int gap);
      i_data  = b;
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (gap) begin
         @(posedge i_clk); #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 31; k >= 0; k--) send_bit(w[k], gap);
   endtask

   // Sends nbits payload bits; data packets push each byte to the scoreboard
   // as its 8th bit is driven, except drop_idx. hold > 0 keeps i_ready low
   // for the first hold byte times.
   task automatic send_payload(input bit is_data, input int mode, input int gap,
                               input int drop_idx, input int hold, input int nbits);
      logic [7:0] v;
      if (hold > 0) i_ready = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         v = pay(mode, b / 8);
         if (is_data && (b % 8 == 7) && (b / 8 != drop_idx))
            exp_q.push_back({(b / 8 == PAY_BYTES - 1), v});
         send_bit(v[7 - (b % 8)], gap);
         if (hold > 0 && b == hold * 8 - 1) i_ready = 1'b1;
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         @(posedge i_clk); #1;
      end
      repeat (3) begin
         @(posedge i_clk); #1;
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},    o_valid,    0);
      check({tag, "_data"},     o_data,     0);
      check({tag, "_last"},     o_last,     0);
      check({tag, "_locked"},   o_locked,   0);
      check({tag, "_lock_err"}, o_lock_err, 0);
      check({tag, "_overflow"}, o_overflow, 0);
   endtask

   initial begin
      i_reset = 1'b1;
      i_valid = 1'b0;
      i_data  = 1'b0;
      i_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      @(posedge i_clk); #1;
      check_reset_outputs("reset");

      // Data packet after filler bits
      send_word(32'h0, 0);
      check("locked_before_sync", o_locked, 0);
      send_word(P_DATA, 0);
      check("locked_after_sync", o_locked, 1);
      send_payload(1'b1, 0, 0, -1, 0, PAY_BYTES * 8);
      drain("drain_first");

      // Idle packet then data packet back-to-back
      send_word(P_IDLE, 0);
      send_payload(1'b0, 2, 0, -1, 0, PAY_BYTES * 8);
      check("idle_no_bytes", o_valid, 0);
      check("idle_locked", o_locked, 1);
      send_word(P_DATA, 0);
      send_payload(1'b1, 1, 0, -1, 0, PAY_BYTES * 8);
      drain("drain_idle_data");
      check("no_lock_err_yet", n_lock_err, 0);

      // Good packet, then a sync word with its last bit flipped
      send_word(P_DATA, 0);
      send_payload(1'b1, 0, 0, -1, 0, PAY_BYTES * 8);
      send_word(P_DATA ^ 32'h1, 0);
      check("lock_err_pulse", o_lock_err, 1);
      check("locked_lost", o_locked, 0);
      @(posedge i_clk); #1;
      check("lock_err_one_cycle", o_lock_err, 0);
      drain("drain_before_corrupt");
      send_word(32'h0, 0);
      send_word(P_DATA, 0);
      check("relocked", o_locked, 1);
      send_payload(1'b1, 1, 0, -1, 0, PAY_BYTES * 8);
      drain("drain_relock");
      check("lock_err_count", n_lock_err, 1);

      // Backpressure: five byte times stalled, the fifth byte is lost
      check("overflow_clear", o_overflow, 0);
      send_word(P_DATA, 0);
      send_payload(1'b1, 0, 0, 4, 5, 5 * 8);
      check("overflow_set", o_overflow, 1);
      send_payload(1'b1, 0, 0, -1, 0, 0);
      // remaining bytes of the same packet
      for (int b = 5 * 8; b < PAY_BYTES * 8; b++) begin
         logic [7:0] v;
         v = pay(0, b / 8);
         if (b % 8 == 7) exp_q.push_back({(b / 8 == PAY_BYTES - 1), v});
         send_bit(v[7 - (b % 8)], 0);
      end
      drain("drain_backpressure");
      check("overflow_sticky", o_overflow, 1);

      // Reset in the middle of a packet with bytes queued
      i_ready = 1'b0;
      send_word(P_DATA, 0);
      send_payload(1'b1, 1, 0, -1, 0, 100);
      check("fifo_holds_bytes", o_valid, 1);
      i_reset = 1'b1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      exp_q.delete();
      check_reset_outputs("midreset");
      i_ready = 1'b1;
      send_word(32'h0, 0);
      send_word(P_DATA, 0);
      check("locked_after_reset", o_locked, 1);
      send_payload(1'b1, 1, 0, -1, 0, PAY_BYTES * 8);
      drain("drain_after_reset");

      // Sparse valid: one bit every third cycle
      send_word(P_DATA, 2);
      check("sparse_locked", o_locked, 1);
      send_payload(1'b1, 0, 2, -1, 0, PAY_BYTES * 8);
      drain("drain_sparse");

      check("final_lock_err_count", n_lock_err, 1);
      check("final_overflow", o_overflow, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/unpack.md
# unpack

Receive-side counterpart of the packet generator. It takes the serial bit stream produced by the transmit path (fixed-length packets of `SIZE_BIT_PACK` bits: a 32-bit sync word followed by payload bits, MSB of each byte first) and finds packet boundaries by sync-word search. It then tracks lock across consecutive packets, discards idle packets, and reassembles data payload into bytes. Bytes leave through a small ready/valid FIFO toward the downstream byte consumer.

## Interface
- `SIZE_BIT_PACK`, 1976, packet length in bits including sync word
- `SIZE_PREAMBLE`, 32, sync word length in bits
- `SIZE_OUTPUT_BIT`, 8, output byte width
- `PREAMBLE_DATA`, 32'h1ACFFC1D, sync word of a data packet
- `PREAMBLE_IDLE`, 32'hE53003E2, sync word of an idle packet
- `FIFO_DEPTH`, 4, output FIFO depth in bytes (power of two, ≥2)
- `i_clk`, in, 1, clock
- `i_reset`, in, 1, reset i_reset, synchronous, active-high (clock i_clk)
- `i_data`, in, 1, serial bit
- `i_valid`, in, 1, `i_data` strobe; the stream cannot be stalled
- `o_data`, out, 8, payload byte; first received bit is in bit 7
- `o_last`, out, 1, qualifies `o_data` as the last byte of a packet
- `o_valid`, out, 1, FIFO not empty
- `i_ready`, in, 1, consumer accepts byte when `o_valid && i_ready`
- `o_locked`, out, 1, sync tracking established
- `o_lock_err`, out, 1, one-cycle pulse on sync loss
- `o_overflow`, out, 1, sticky: a byte was dropped because the FIFO was full

## Operation
- Shift register `sr[31:0]` shifts in on every `i_valid`. The candidate word is `{sr[30:0], i_data}`.
- Payload per packet: `(SIZE_BIT_PACK - SIZE_PREAMBLE)/8` bytes, 243 by default.
- States:
  - **SEARCH**:
    - Compare the candidate word on every valid bit.
    - `PREAMBLE_DATA` → DATA; `PREAMBLE_IDLE` → IDLE.
    - Either match sets `o_locked`.
  - **DATA**: collect payload bits, MSB first, into a byte assembler.
    - Each 8th bit pushes a byte to the FIFO.
    - The final byte of the packet is pushed with `last=1`.
    - After the final payload bit → HDR.
  - **IDLE**: count payload bits and discard them; after the final bit → HDR.
  - **HDR**: count exactly 32 valid bits, then compare the candidate word on the 32nd bit.
    - Data match → DATA; idle match → IDLE.
    - Mismatch → SEARCH: `o_locked` cleared, `o_lock_err` pulsed. The search resumes on the next valid bit with `sr` intact.
- Bit counter: 11 bits for the default length; cleared on every state entry; counts valid bits only.
- FIFO push when it is not full, or when it is full and popping in the same cycle (simultaneous push+pop at full succeeds).
  - A push while full with no pop drops the byte and sets `o_overflow`.
  - A dropped `last` byte is lost as well; no other recovery.
- `o_data`/`o_last` come from the FIFO head; registered output, no combinational path from `i_valid` to `o_valid`.
- Idle packets never produce bytes.

## Timing
- Reset values: state SEARCH, `sr`=0, counters 0, FIFO empty, `o_valid`=0, `o_data`=0, `o_last`=0, `o_locked`=0, `o_lock_err`=0, `o_overflow`=0.
- Reset mid-packet discards the partial byte and FIFO contents; the next bit is treated as search.
- Sync decision happens on the edge that samples the 32nd sync bit.
- The first payload bit is the next valid bit.
- Byte latency: the byte is in the FIFO at the edge sampling its 8th bit; `o_valid`=1 in the following cycle.
- `o_lock_err` is high exactly one cycle, the cycle after the failing edge.
- `o_locked` rises the cycle after the first match and falls together with `o_lock_err`.
- Gaps in `i_valid` are allowed anywhere; state and counters hold.

## Test plan
- **Data packet**: 32 random bits, then a data packet carrying payload bytes 0x00..0xF2, `i_ready`=1 → 243 bytes 0x00..0xF2 in order; only 0xF2 has `o_last`=1; `o_locked`=1 after the sync word.
- **Idle then data**: idle packet then data packet back-to-back → no bytes during idle; data bytes correct; `o_lock_err` never asserted.
- **Corrupted sync**: two data packets, second sync word with one bit flipped → first packet fully delivered; `o_lock_err` pulses once at the 32nd bit; `o_locked`=0; a later correct packet re-locks.
- **Backpressure**: `i_ready`=0 for 5 byte times with `FIFO_DEPTH`=4 → bytes 0–3 retained, byte 4 dropped, `o_overflow`=1 and stays 1; after `i_ready`=1, bytes 0,1,2,3,5,… are delivered.
- **Reset mid-packet**: `i_reset` at payload bit 100, then a clean packet → all outputs at reset values; the clean packet is received correctly with no stale bytes.
- **Sparse valid**: `i_valid` asserted every 3rd cycle → same byte sequence as the dense case.
